// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter for the CPU bridge.
// Stores to DATA queue bytes in a small circular FIFO; a four-state
// serialiser drains it LSB first on txd. CTRL holds the bit period and the
// enables, STAT reports shifter/queue status, and irq flags a drained queue.

module uart_tx_dev #(
    parameter int FIFO_DEPTH  = 4,
    parameter int DIV_DEFAULT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        irq,
    output logic        txd
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    bitCnt_q, bitCnt_d;
    logic [15:0]   period_q, period_d;
    logic [15:0]   frameDiv_q, frameDiv_d;
    logic [7:0]    shift_q, shift_d;

    logic [15:0]   div_q;
    logic          ien_q;
    logic          ten_q;
    logic          ovr_q;
    logic          irq_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;

    logic          dataWrite;
    logic          ctrlWrite;
    logic          statWrite;
    logic          fifoFull;
    logic          fifoEmpty;
    logic          push;
    logic          pop;
    logic          overflow;
    logic          periodDone;
    logic          busy;
    logic [4:0]    countExt;
    logic          unusedWriteBits;

    // Register decode and queue status; a full queue still accepts a byte
    // when the shifter pops in the same cycle.
    assign dataWrite  = write_enable && (addr == 2'd0);
    assign ctrlWrite  = write_enable && (addr == 2'd1);
    assign statWrite  = write_enable && (addr == 2'd2);
    assign fifoFull   = (count_q == CW'(FIFO_DEPTH));
    assign fifoEmpty  = (count_q == '0);
    assign push       = dataWrite && (!fifoFull || pop);
    assign overflow   = dataWrite && fifoFull && !pop;
    assign periodDone = (period_q == 16'd0);
    assign countExt   = 5'(count_q);
    assign unusedWriteBits = ^write_data[31:18];
    assign irq        = irq_q;

    // Serialiser state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Serialiser next state: each non-idle state holds for one bit period,
    // and STOP chains straight into START when another byte is waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (ten_q && !fifoEmpty) state_d = START;
            START: if (periodDone) state_d = DATA;
            DATA:  if (periodDone && (bitCnt_q == 3'd7)) state_d = STOP;
            STOP:  if (periodDone) state_d = (ten_q && !fifoEmpty) ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Serialiser outputs: line level, busy flag and the queue pop strobe.
    always_comb begin
        txd  = 1'b1;
        busy = 1'b1;
        pop  = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                pop  = ten_q && !fifoEmpty;
            end
            START: txd = 1'b0;
            DATA:  txd = shift_q[0];
            STOP:  pop = periodDone && ten_q && !fifoEmpty;
            default: busy = 1'b0;
        endcase
    end

    // Bit/period counters and shifter; the divisor is captured at the pop so
    // a CTRL write mid-frame only affects the following frame.
    always_comb begin
        bitCnt_d   = bitCnt_q;
        period_d   = period_q;
        frameDiv_d = frameDiv_q;
        shift_d    = shift_q;
        if (pop) begin
            shift_d    = mem_q[rdPtr_q];
            period_d   = div_q - 16'd1;
            frameDiv_d = div_q;
            bitCnt_d   = 3'd0;
        end else if (state_q != IDLE) begin
            if (periodDone) begin
                period_d = frameDiv_q - 16'd1;
                if (state_q == DATA) begin
                    shift_d  = {1'b0, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 3'd1;
                end
            end else begin
                period_d = period_q - 16'd1;
            end
        end
    end

    // Datapath registers behind the serialiser.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitCnt_q   <= 3'd0;
            period_q   <= 16'd0;
            frameDiv_q <= 16'(DIV_DEFAULT);
            shift_q    <= 8'd0;
        end else begin
            bitCnt_q   <= bitCnt_d;
            period_q   <= period_d;
            frameDiv_q <= frameDiv_d;
            shift_q    <= shift_d;
        end
    end

    // Circular byte queue with wrapping pointers and an occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wrPtr_q] <= write_data[7:0];
                wrPtr_q        <= wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Control/status registers; a zero divisor would stall the shifter, so it
    // is stored as one. OVR is sticky until software writes 1 to bit 3.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= 16'(DIV_DEFAULT);
            ien_q <= 1'b0;
            ten_q <= 1'b1;
            ovr_q <= 1'b0;
        end else begin
            if (ctrlWrite) begin
                div_q <= (write_data[15:0] == 16'd0) ? 16'd1 : write_data[15:0];
                ien_q <= write_data[16];
                ten_q <= write_data[17];
            end
            if (overflow) begin
                ovr_q <= 1'b1;
            end else if (statWrite && write_data[3]) begin
                ovr_q <= 1'b0;
            end
        end
    end

    // Registered interrupt: raised once the queue is drained and the line idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ien_q && fifoEmpty && !busy;
        end
    end

    // Zero-latency register read mux for the bridge.
    always_comb begin
        read_data = 32'd0;
        case (addr)
            2'd1:    read_data = {14'd0, ten_q, ien_q, div_q};
            2'd2:    read_data = {23'd0, countExt, ovr_q, fifoEmpty, fifoFull, busy};
            default: read_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: directed bench for the UART transmitter. Register values
// are hand-derived constants; line waveforms are built from a small frame
// model (start bit, eight data bits LSB first, stop bit, DIV samples each).

module tb_uart_tx_dev;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        irq;
    logic        txd;

    int checkCount;
    int failCount;

    bit obsTxd[$];
    bit obsBusy[$];
    bit obsIrq[$];
    bit expTxd[$];

    uart_tx_dev #(
        .FIFO_DEPTH (4),
        .DIV_DEFAULT(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .write_enable(write_enable),
        .write_data  (write_data),
        .read_data   (read_data),
        .irq         (irq),
        .txd         (txd)
    );

    // Free-running 10-unit clock; the DUT acts on the rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so a broken design can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One bridge store: driven on a falling edge, captured on the next rise.
    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr         = a;
        write_data   = d;
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
        write_data   = 32'd0;
        addr         = 2'd2;
    endtask

    // Combinational register read checked a little after the address settles.
    task automatic readReg(input logic [1:0] a, input logic [31:0] expected,
                           input string tag);
        addr = a;
        #1;
        checkOutput(tag, read_data, expected);
        addr = 2'd2;
    endtask

    // Record txd, BUSY (addr parked on STAT) and irq once per cycle.
    task automatic captureWave(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            #1;
            obsTxd.push_back(txd);
            obsBusy.push_back(read_data[0]);
            obsIrq.push_back(irq);
        end
    endtask

    task automatic clearWaves();
        obsTxd.delete();
        obsBusy.delete();
        obsIrq.delete();
        expTxd.delete();
    endtask

    // Expected line for one 8N1 frame at the given bit period.
    task automatic addFrame(input logic [7:0] b, input int div);
        for (int k = 0; k < div; k++) expTxd.push_back(1'b0);
        for (int bitIdx = 0; bitIdx < 8; bitIdx++) begin
            for (int k = 0; k < div; k++) expTxd.push_back(b[bitIdx]);
        end
        for (int k = 0; k < div; k++) expTxd.push_back(1'b1);
    endtask

    task automatic addIdle(input int n);
        for (int k = 0; k < n; k++) expTxd.push_back(1'b1);
    endtask

    // Compare recorded line against the model; reports the bad-sample count.
    task automatic compareWave(input string tag);
        int errs;
        errs = 0;
        if (obsTxd.size() != expTxd.size()) errs = errs + 1000;
        for (int i = 0; i < obsTxd.size() && i < expTxd.size(); i++) begin
            if (obsTxd[i] != expTxd[i]) errs++;
        end
        checkOutput(tag, errs, 0);
    endtask

    function automatic int countOnes(input bit q[$]);
        int n;
        n = 0;
        foreach (q[i]) if (q[i]) n++;
        return n;
    endfunction

    // Directed scenario sequence.
    initial begin
        checkCount   = 0;
        failCount    = 0;
        reset        = 1'b0;
        addr         = 2'd2;
        write_enable = 1'b0;
        write_data   = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;

        // Reset state and register map.
        checkOutput("rst_txd", txd, 1);
        checkOutput("rst_irq", irq, 0);
        readReg(2'd0, 32'h0, "rst_data");
        readReg(2'd1, 32'h20010, "rst_ctrl");
        readReg(2'd2, 32'h004, "rst_stat");
        readReg(2'd3, 32'h0, "rst_off3");

        // Single frame 0xA5 at DIV=2.
        applyStimulus(2'd1, 32'h20002);
        applyStimulus(2'd0, 32'hA5);
        clearWaves();
        captureWave(22);
        addFrame(8'hA5, 2);
        addIdle(2);
        compareWave("wave_a5");
        checkOutput("busy_a5", countOnes(obsBusy), 20);
        readReg(2'd2, 32'h004, "stat_after_a5");

        // CTRL masking, zero divisor and the dead offset.
        applyStimulus(2'd1, 32'hFFFF_0000);
        readReg(2'd1, 32'h30001, "ctrl_mask");
        applyStimulus(2'd3, 32'hFFFF_FFFF);
        readReg(2'd3, 32'h0, "off3_write");
        readReg(2'd2, 32'h004, "stat_off3");
        checkOutput("irq_idle_ien", irq, 1);

        // Overflow with TEN=0, OVR clear, then back-to-back drain.
        applyStimulus(2'd1, 32'h00002);
        applyStimulus(2'd0, 32'h11);
        applyStimulus(2'd0, 32'h22);
        applyStimulus(2'd0, 32'h33);
        applyStimulus(2'd0, 32'h44);
        applyStimulus(2'd0, 32'h55);
        readReg(2'd2, 32'h04A, "stat_full_ovr");
        applyStimulus(2'd2, 32'h8);
        readReg(2'd2, 32'h042, "stat_ovr_clr");
        readReg(2'd1, 32'h00002, "ctrl_ten0");
        applyStimulus(2'd1, 32'h20002);
        clearWaves();
        captureWave(84);
        addFrame(8'h11, 2);
        addFrame(8'h22, 2);
        addFrame(8'h33, 2);
        addFrame(8'h44, 2);
        addIdle(4);
        compareWave("wave_b2b");
        checkOutput("busy_b2b", countOnes(obsBusy), 80);
        readReg(2'd2, 32'h004, "stat_drained");

        // Interrupt timing at DIV=1.
        applyStimulus(2'd1, 32'h00001);
        applyStimulus(2'd0, 32'h5A);
        applyStimulus(2'd0, 32'h0F);
        checkOutput("irq_queued", irq, 0);
        applyStimulus(2'd1, 32'h30001);
        clearWaves();
        captureWave(24);
        addFrame(8'h5A, 1);
        addFrame(8'h0F, 1);
        addIdle(4);
        compareWave("wave_irq");
        checkOutput("busy_irq", countOnes(obsBusy), 20);
        checkOutput("irq_before", obsIrq[20], 0);
        checkOutput("irq_rise", obsIrq[21], 1);
        checkOutput("irq_ones", countOnes(obsIrq), 3);
        applyStimulus(2'd1, 32'h20001);
        checkOutput("irq_hold", irq, 1);
        @(negedge clk);
        #1;
        checkOutput("irq_drop", irq, 0);

        // Divisor change during DATA bit 3 only affects the next frame.
        applyStimulus(2'd1, 32'h00004);
        applyStimulus(2'd0, 32'h3C);
        applyStimulus(2'd0, 32'hC3);
        applyStimulus(2'd1, 32'h20004);
        clearWaves();
        fork
            captureWave(54);
            begin
                repeat (16) @(negedge clk);
                applyStimulus(2'd1, 32'h20001);
            end
        join
        addFrame(8'h3C, 4);
        addFrame(8'hC3, 1);
        addIdle(4);
        compareWave("wave_divchg");
        readReg(2'd1, 32'h20001, "ctrl_divchg");

        // Reset pulse in the middle of DATA.
        applyStimulus(2'd1, 32'h00004);
        applyStimulus(2'd0, 32'h00);
        applyStimulus(2'd0, 32'h00);
        applyStimulus(2'd1, 32'h20004);
        repeat (10) @(negedge clk);
        #1;
        checkOutput("txd_mid_data", txd, 0);
        reset = 1'b0;
        #1;
        checkOutput("txd_async_rst", txd, 1);
        readReg(2'd2, 32'h004, "stat_in_rst");
        @(negedge clk);
        reset = 1'b1;
        clearWaves();
        captureWave(40);
        addIdle(40);
        compareWave("wave_after_rst");
        checkOutput("busy_after_rst", countOnes(obsBusy), 0);
        readReg(2'd2, 32'h004, "stat_after_rst");
        readReg(2'd1, 32'h20010, "ctrl_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_tx_dev.md
# uart_tx_dev

Memory-mapped UART transmitter on the CPU's bridge, alongside the two timers. The memory stage drives register writes through the bridge's decoded device address and write enable. Bytes written are queued in a small FIFO and serialised 8N1, LSB first, on `txd`. A level interrupt on `irq` feeds one `hw_int` bit of CP0 when the queue drains.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: byte queue entries; must be a power of two, 2..16.
- `DIV_DEFAULT`, default 16: reset value of the bit-period divisor, in clocks.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `addr`  in  2  word offset within the device (bridge `dev_addr[3:2]`).
- `write_enable`  in  1  register write strobe from the bridge, one cycle per store.
- `write_data`  in  32  store data (`m_read_data`).
- `read_data`  out  32  combinational register read for the current `addr`.
- `irq`  out  1  level interrupt request.
- `txd`  out  1  serial line, idles high.

## Operation

Register map:
- offset 0, DATA:
  - Write pushes `write_data[7:0]` into the FIFO.
  - If the FIFO is full, the byte is dropped and OVR is set.
  - Reads return 0.
- offset 1, CTRL:
  - `[15:0]` DIV, the bit period in clocks; a write of 0 is stored as 1.
  - `[16]` IEN, interrupt enable.
  - `[17]` TEN, transmit enable.
  - Other bits read 0.
  - Fully read/write.
- offset 2, STAT (read-only except OVR):
  - `[0]` BUSY, shifter not in IDLE.
  - `[1]` FULL.
  - `[2]` EMPTY.
  - `[3]` OVR, sticky.
  - `[8:4]` COUNT, FIFO occupancy.
  - A write with `write_data[3]`=1 clears OVR; all other bits of the write are ignored.
- offset 3: reads 0; writes ignored.

Serialiser FSM:
- States: IDLE, START, DATA, STOP. A bit counter runs 0..7 and a period counter runs DIV-1..0.
- IDLE, `txd`=1: if TEN=1 and the FIFO is not empty, pop the head into the shift register, latch DIV into the period counter and go to START.
- START, `txd`=0: lasts DIV cycles, then go to DATA with bit counter 0.
- DATA, `txd`=shift[0]: each bit lasts DIV cycles, then shift right; after bit 7 go to STOP.
- STOP, `txd`=1: lasts DIV cycles. At its end, if TEN=1 and the FIFO is not empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- DIV is sampled once at the pop, so a CTRL write during a frame affects only the next frame.
- Clearing TEN mid-frame completes the current frame, then holds in IDLE.

Interrupt:
- `irq` = IEN & EMPTY & ~BUSY, registered. It is asserted one cycle after the condition becomes true.

FIFO:
- Circular buffer with wrap-around read/write pointers and a COUNT of width log2(FIFO_DEPTH)+1.
- A simultaneous push and pop in the same cycle is always accepted, including when the FIFO is full (COUNT unchanged, no OVR).

## Timing

Reset values:
- `txd`=1, `irq`=0.
- FSM in IDLE, FIFO empty, OVR=0.
- DIV=`DIV_DEFAULT`, IEN=0, TEN=1.
- Hence STAT reads 0x004 and CTRL reads 0x20000|`DIV_DEFAULT`.

Latency and frame timing:
- DATA write captured at edge N gives EMPTY=0 after N.
- The FSM pops at N+1, and `txd` falls after N+1.
- A frame lasts exactly 10×DIV cycles. Back-to-back frames have no gap.

Read path:
- `read_data` is purely combinational from `addr` and current state, with zero-cycle latency, matching the timers.

Reset assertion:
- Asserting `reset` mid-frame forces `txd`=1 asynchronously and discards FIFO contents.

## Test plan

- Reset, then read offsets 0–3 -> 0, 0x20010, 0x004, 0 with DIV_DEFAULT=16; `txd`=1, `irq`=0.
- Write CTRL=0x20002, then DATA=0xA5 -> `txd` low 2 cycles, then bits 1,0,1,0,0,1,0,1 for 2 cycles each, then high 2 cycles; BUSY=1 for exactly 20 cycles.
- With TEN=0, write 5 bytes into a depth-4 FIFO -> STAT reads FULL=1, COUNT=4, OVR=1. Write STAT=0x8 -> OVR=0. Set TEN -> the first 4 bytes are sent back-to-back in 40×DIV cycles.
- IEN=1 and DIV=1, write 2 bytes -> `irq`=0 while sending and rises exactly 1 cycle after the second STOP ends. Clearing IEN drops `irq` the next cycle.
- With DIV=4, write DIV=1 during DATA bit 3 of a frame -> the remaining bits of that frame stay 4 cycles each; the next frame uses 1-cycle bits.
- Pulse `reset` low mid-DATA -> `txd`=1 immediately, STAT=0x004, and no further output bits.
